pattern_count_engine: RTL and testbench
=======================================

# pattern_count_engine

Hardware accelerator for the program-3 pattern-search workload. On a `start` request it reads a PAT_W-bit pattern and an N_BYTES-byte message from data memory and computes three counts: in-byte matches, bytes holding at least one match, and matches across the whole bit string (byte-crossing allowed). It writes the counts back to memory and raises `ack`. It sits beside the core on the data-memory port and generalises the fixed 5-bit / 32-byte software version in pattern width, message length and memory addresses.

## Interface
- PAT_W, 5, pattern width in bits; legal 2..8
- N_BYTES, 32, message length in bytes; legal 1..128
- ADDR_W, 8, data-memory address width
- MSG_ADDR, 0, address of message byte 0
- PAT_ADDR, 32, pattern byte address; pattern is left-justified in bits [7:8-PAT_W]
- RES_ADDR, 33, result base; in-byte count at +0, byte count at +1, string count at +2
- CNT_W, $clog2(8*N_BYTES+1), width of the result ports

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  run request, sampled high in IDLE or DONE
- ack  out  1  high in DONE until the next accepted start or reset
- mem_addr  out  ADDR_W  read/write address
- mem_rd_data  in  8  synchronous read data, valid one cycle after the address
- mem_wr_en  out  1  write strobe
- mem_wr_data  out  8  write data
- cnt_inbyte  out  CNT_W  windows fully inside one byte that match
- cnt_bytes  out  CNT_W  bytes with at least one in-byte match
- cnt_string  out  CNT_W  matches over the concatenated string

## Operation
- Bit string: byte MSG_ADDR+0 comes first, MSB first within each byte.
- String windows: 8*N_BYTES-PAT_W+1 windows at every bit offset.
- In-byte windows: 9-PAT_W windows per byte, at bits [PAT_W-1+k:k].
- FSM states:
  - IDLE: no activity.
  - RD_PAT: drives PAT_ADDR.
  - SCAN: drives MSG_ADDR+i for i=0..N_BYTES-1.
    - In the first SCAN cycle the pattern is captured from mem_rd_data.
    - In each later SCAN cycle, byte i-1 is processed.
  - DRAIN: processes the last byte.
  - WR0, WR1, WR2: write the three results.
  - DONE: results held; start is accepted here.
- Byte processing:
  - A carry register holds the previous byte's low PAT_W-1 bits.
  - String matches are counted for windows ending in each bit of the new byte.
  - Windows are counted only once at least PAT_W bits have been seen in total, so the first byte contributes only 9-PAT_W windows.
  - For every byte, the in-byte count and the byte flag are updated in the same cycle.
- Counters:
  - CNT_W bits wide.
  - Cleared when start is accepted.
  - They cannot overflow by construction.
- Memory write-back: each count saturates to 8'hFF when it exceeds 255. The ports always carry the full-width values.
- mem_wr_en is high only in WR0..WR2; mem_wr_data is 0 otherwise.
- start outside IDLE/DONE is ignored. Asserting start for many cycles starts exactly one run per visit to IDLE/DONE.
- Reset behaviour:
  - Applies at any time, including mid-scan.
  - Forces IDLE, with all counters, the carry register and the captured pattern cleared.
  - No write is issued after reset.

## Timing
- Reset values: ack=0, mem_addr=0, mem_wr_en=0, mem_wr_data=0, all cnt_* = 0.
- Cycle numbering: start is sampled at edge 0.
  - Edge 0 to cycle 1: RD_PAT.
  - Cycles 2..N_BYTES+1: SCAN.
  - Cycle N_BYTES+2: DRAIN.
  - Cycles N_BYTES+3..+5: WR0..WR2.
  - ack first high in cycle N_BYTES+6 (38 for the defaults).
- cnt_* ports are final from WR0 onward and held stable through DONE.
- ack falls in the cycle after a start accepted in DONE.
- Single-cycle throughput: one byte per clock, with no stall input.

## Structure
- pattern_pkg holds:
  - the FSM state enum;
  - localparams for the window counts;
  - a saturate-to-8-bit function.
- One sub-module, window_match (combinational):
  - Inputs: {carry, byte}, the pattern, and a valid-bit count.
  - Outputs: the in-byte hit count, the any-hit flag and the string hit count for that byte.
- pattern_count_engine holds the FSM, address counter, carry register and accumulators.

## Test plan
- Defaults, all bytes 0x00, pattern 00000 -> 128 / 32 / 252 on the ports and in memory 33..35; ack in cycle 38.
- Defaults, bytes 0x55, pattern 10101 -> 64 / 32 / 126.
- Defaults, byte0=0x03, byte1=0xE0, rest 0x00, pattern 11111 -> 0 / 0 / 1 (crossing only).
- PAT_W=2, N_BYTES=64, all zeros, pattern 00 -> ports 448 / 64 / 511; memory FF / 40 / FF.
- Defaults, start re-pulsed mid-SCAN -> ignored and results unchanged. Reset at SCAN i=10 -> IDLE with no writes to 33..35, then a clean rerun gives correct counts.
- Back-to-back runs: start in DONE with a new message -> ack drops next cycle, counters restart from 0, and the second results are correct.

Source files
------------

// File: rtl/pattern_pkg.sv
// ---------------------------------------------------------------------------
// pattern_pkg
// Shared definitions for the pattern-count engine: controller state encoding,
// fixed byte/window geometry, helper for window counts and the 8-bit
// saturation applied when results are written back to data memory.
// ---------------------------------------------------------------------------
package pattern_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_PAT,
        ST_SCAN,
        ST_DRAIN,
        ST_WR0,
        ST_WR1,
        ST_WR2,
        ST_DONE
    } state_t;

    localparam int BYTE_BITS   = 8;
    // At most one string window ends in each bit of a new byte.
    localparam int MAX_WINDOWS = BYTE_BITS;
    // Width of per-byte hit counts (0..MAX_WINDOWS).
    localparam int HIT_W       = 4;
    // Width of the valid-bit count fed to the matcher (up to 15).
    localparam int VB_W        = 4;

    // Windows fully contained in one byte for a given pattern width.
    function automatic int inbyte_windows(input int pat_w);
        return BYTE_BITS - pat_w + 1;
    endfunction

    function automatic logic [7:0] sat8(input int unsigned v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/window_match.sv
// ---------------------------------------------------------------------------
// window_match
// Combinational matcher for one message byte. window_bits is {carry, byte}:
// the previous byte's low PAT_W-1 bits sit above the new byte, so bit k of the
// vector is later in the bit string than bit k+1. Window k is
// window_bits[k+PAT_W-1:k]; it ends inside the new byte for every k in 0..7.
//
// Ports:
//   window_bits  in   {carry, byte}
//   pattern      in   pattern, MSB first
//   valid_bits   in   how many LSBs of window_bits hold real string bits
//   inbyte_hits  out  matches among windows fully inside the byte
//   any_hit      out  at least one in-byte match
//   string_hits  out  matches among valid windows ending in the byte
// ---------------------------------------------------------------------------
module window_match
    import pattern_pkg::*;
#(
    parameter int PAT_W = 5
) (
    input  logic [PAT_W+BYTE_BITS-2:0] window_bits,
    input  logic [PAT_W-1:0]           pattern,
    input  logic [VB_W-1:0]            valid_bits,
    output logic [HIT_W-1:0]           inbyte_hits,
    output logic                       any_hit,
    output logic [HIT_W-1:0]           string_hits
);

    localparam int INB_WIN = inbyte_windows(PAT_W);

    always_comb begin
        inbyte_hits = '0;
        string_hits = '0;
        for (int k = 0; k < MAX_WINDOWS; k++) begin
            if (window_bits[k +: PAT_W] == pattern) begin
                if (k < INB_WIN) begin
                    inbyte_hits = inbyte_hits + HIT_W'(1);
                end
                // Windows reaching into carry bits that were never loaded
                // (first byte of a run) are excluded.
                if ((k + PAT_W) <= int'(valid_bits)) begin
                    string_hits = string_hits + HIT_W'(1);
                end
            end
        end
    end

    assign any_hit = |inbyte_hits;

endmodule

// File: rtl/pattern_count_engine.sv
// ---------------------------------------------------------------------------
// pattern_count_engine
// Reads a PAT_W-bit pattern and an N_BYTES-byte message from a synchronous
// data memory, counts in-byte matches, bytes with a match and matches across
// the whole bit string, writes the three counts (saturated to 8 bits) back to
// memory and raises ack. One message byte is processed per clock.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               run request, accepted in IDLE or DONE
//   ack                 high in DONE
//   mem_addr            memory address (registered)
//   mem_rd_data         read data, valid one cycle after the address
//   mem_wr_en/_data     write strobe and data (WR0..WR2 only)
//   cnt_inbyte/_bytes/_string   full-width result counts
// ---------------------------------------------------------------------------
module pattern_count_engine
    import pattern_pkg::*;
#(
    parameter int PAT_W    = 5,
    parameter int N_BYTES  = 32,
    parameter int ADDR_W   = 8,
    parameter int MSG_ADDR = 0,
    parameter int PAT_ADDR = 32,
    parameter int RES_ADDR = 33,
    parameter int CNT_W    = $clog2(8 * N_BYTES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              ack,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic [CNT_W-1:0]  cnt_inbyte,
    output logic [CNT_W-1:0]  cnt_bytes,
    output logic [CNT_W-1:0]  cnt_string
);

    localparam int CW    = PAT_W - 1 + BYTE_BITS;
    localparam int IDX_W = $clog2(N_BYTES + 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic              vld_p0;      // mem_rd_data holds a message byte
    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-2:0]  carry;
    logic              carry_vld;   // carry holds real bits (not first byte)

    logic [HIT_W-1:0]  inb_hits;
    logic [HIT_W-1:0]  str_hits;
    logic              any_hit;
    logic [VB_W-1:0]   vbits;
    logic [CNT_W-1:0]  inbyte_nxt;
    logic [CNT_W-1:0]  bytes_nxt;
    logic [CNT_W-1:0]  string_nxt;

    assign vbits = carry_vld ? VB_W'(CW) : VB_W'(BYTE_BITS);

    window_match #(.PAT_W(PAT_W)) u_match (
        .window_bits (({carry, mem_rd_data})),
        .pattern     (pattern),
        .valid_bits  (vbits),
        .inbyte_hits (inb_hits),
        .any_hit     (any_hit),
        .string_hits (str_hits)
    );

    assign inbyte_nxt = cnt_inbyte + CNT_W'(inb_hits);
    assign bytes_nxt  = cnt_bytes  + CNT_W'(any_hit);
    assign string_nxt = cnt_string + CNT_W'(str_hits);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            vld_p0      <= 1'b0;
            pattern     <= '0;
            carry       <= '0;
            carry_vld   <= 1'b0;
            cnt_inbyte  <= '0;
            cnt_bytes   <= '0;
            cnt_string  <= '0;
            ack         <= 1'b0;
            mem_addr    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= '0;
        end else begin
            // ---- stage p0: byte returned by memory is accumulated ----
            vld_p0 <= (state == ST_SCAN);
            if (vld_p0) begin
                cnt_inbyte <= inbyte_nxt;
                cnt_bytes  <= bytes_nxt;
                cnt_string <= string_nxt;
                carry      <= mem_rd_data[PAT_W-2:0];
                carry_vld  <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_RD_PAT;
                        mem_addr   <= ADDR_W'(PAT_ADDR);
                        ack        <= 1'b0;
                        cnt_inbyte <= '0;
                        cnt_bytes  <= '0;
                        cnt_string <= '0;
                        carry      <= '0;
                        carry_vld  <= 1'b0;
                    end
                end
                ST_RD_PAT: begin
                    state    <= ST_SCAN;
                    idx      <= '0;
                    mem_addr <= ADDR_W'(MSG_ADDR);
                end
                ST_SCAN: begin
                    // Pattern read issued in RD_PAT returns in the first SCAN cycle.
                    if (idx == '0) begin
                        pattern <= mem_rd_data[7 -: PAT_W];
                    end
                    if (idx == IDX_W'(N_BYTES - 1)) begin
                        state    <= ST_DRAIN;
                        mem_addr <= '0;
                    end else begin
                        idx      <= idx + IDX_W'(1);
                        mem_addr <= ADDR_W'(MSG_ADDR) + ADDR_W'(idx) + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Last byte is accumulated on this edge, so use the next value.
                    state       <= ST_WR0;
                    mem_addr    <= ADDR_W'(RES_ADDR);
                    mem_wr_en   <= 1'b1;
                    mem_wr_data <= sat8(32'(inbyte_nxt));
                end
                ST_WR0: begin
                    state       <= ST_WR1;
                    mem_addr    <= ADDR_W'(RES_ADDR + 1);
                    mem_wr_data <= sat8(32'(cnt_bytes));
                end
                ST_WR1: begin
                    state       <= ST_WR2;
                    mem_addr    <= ADDR_W'(RES_ADDR + 2);
                    mem_wr_data <= sat8(32'(cnt_string));
                end
                ST_WR2: begin
                    state       <= ST_DONE;
                    mem_addr    <= '0;
                    mem_wr_en   <= 1'b0;
                    mem_wr_data <= '0;
                    ack         <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_count_engine.sv
// ---------------------------------------------------------------------------
// tb_pattern_count_engine
// Directed bench for pattern_count_engine. Instance A uses default parameters
// (5-bit pattern, 32 bytes, results at 33..35); instance B uses a 2-bit
// pattern over 64 bytes with the pattern at 100 and results at 101..103.
// Each instance has its own memory model: a message/pattern image written by
// the stimulus and a 3-entry result store written only by the DUT.
// ---------------------------------------------------------------------------
module tb_pattern_count_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a;
    logic start_b;
    logic clr_res;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance A: defaults ----------------
    logic       ack_a;
    logic [7:0] addr_a;
    logic [7:0] rd_a;
    logic       wr_en_a;
    logic [7:0] wr_data_a;
    logic [8:0] inb_a, byt_a, str_a;

    logic [7:0] img_a [0:255];
    logic [7:0] res_a [0:2];
    int         wr_hits_a;

    pattern_count_engine u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .start       (start_a),
        .ack         (ack_a),
        .mem_addr    (addr_a),
        .mem_rd_data (rd_a),
        .mem_wr_en   (wr_en_a),
        .mem_wr_data (wr_data_a),
        .cnt_inbyte  (inb_a),
        .cnt_bytes   (byt_a),
        .cnt_string  (str_a)
    );

    always @(posedge clk) begin
        if (clr_res) begin
            for (int i = 0; i < 3; i++) res_a[i] <= 8'h5A;
            wr_hits_a <= 0;
        end else if (wr_en_a && addr_a >= 8'd33 && addr_a <= 8'd35) begin
            res_a[addr_a - 8'd33] <= wr_data_a;
            wr_hits_a <= wr_hits_a + 1;
        end
        rd_a <= img_a[addr_a];
    end

    // ---------------- instance B: PAT_W=2, N_BYTES=64 ----------------
    logic       ack_b;
    logic [7:0] addr_b;
    logic [7:0] rd_b;
    logic       wr_en_b;
    logic [7:0] wr_data_b;
    logic [9:0] inb_b, byt_b, str_b;

    logic [7:0] img_b [0:255];
    logic [7:0] res_b [0:2];

    pattern_count_engine #(
        .PAT_W    (2),
        .N_BYTES  (64),
        .ADDR_W   (8),
        .MSG_ADDR (0),
        .PAT_ADDR (100),
        .RES_ADDR (101)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .start       (start_b),
        .ack         (ack_b),
        .mem_addr    (addr_b),
        .mem_rd_data (rd_b),
        .mem_wr_en   (wr_en_b),
        .mem_wr_data (wr_data_b),
        .cnt_inbyte  (inb_b),
        .cnt_bytes   (byt_b),
        .cnt_string  (str_b)
    );

    always @(posedge clk) begin
        if (clr_res) begin
            for (int i = 0; i < 3; i++) res_b[i] <= 8'h5A;
        end else if (wr_en_b && addr_b >= 8'd101 && addr_b <= 8'd103) begin
            res_b[addr_b - 8'd101] <= wr_data_b;
        end
        rd_b <= img_b[addr_b];
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic clear_res();
        @(negedge clk);
        clr_res = 1'b1;
        @(negedge clk);
        clr_res = 1'b0;
    endtask

    task automatic fill_a(input logic [7:0] v, input logic [7:0] pat);
        for (int i = 0; i < 32; i++) img_a[i] = v;
        img_a[32] = pat;
    endtask

    // One run on instance A. start is sampled at edge 0; the loop visits
    // cycle c at the falling edge after edge c-1. Optional extra start
    // pulses are driven in cycles pulse_from..pulse_to.
    task automatic run_a(input string tag, input int e_inb, input int e_byt, input int e_str,
                         input int pulse_from, input int pulse_to);
        int ack_cyc = 0;
        clear_res();
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start_a = (c >= pulse_from) && (c <= pulse_to);
            if (c == 1) begin
                check_val({tag, "_ack_low_c1"}, 32'(ack_a), 0);
                check_val({tag, "_str_cleared_c1"}, 32'(str_a), 0);
            end
            if (ack_a) begin
                ack_cyc = c;
                break;
            end
        end
        start_a = 1'b0;
        check_val({tag, "_ack_cycle"}, ack_cyc, 38);
        check_val({tag, "_cnt_inbyte"}, 32'(inb_a), e_inb);
        check_val({tag, "_cnt_bytes"},  32'(byt_a), e_byt);
        check_val({tag, "_cnt_string"}, 32'(str_a), e_str);
        check_val({tag, "_mem33"}, 32'(res_a[0]), sat(e_inb));
        check_val({tag, "_mem34"}, 32'(res_a[1]), sat(e_byt));
        check_val({tag, "_mem35"}, 32'(res_a[2]), sat(e_str));
        check_val({tag, "_wr_count"}, wr_hits_a, 3);
        repeat (3) @(negedge clk);
        check_val({tag, "_ack_held"}, 32'(ack_a), 1);
        check_val({tag, "_string_held"}, 32'(str_a), e_str);
        check_val({tag, "_wr_en_idle"}, 32'(wr_en_a), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        clr_res = 1'b0;
        for (int i = 0; i < 256; i++) begin
            img_a[i] = 8'h00;
            img_b[i] = 8'h00;
        end

        repeat (2) @(negedge clk);
        check_val("rst_ack",      32'(ack_a),     0);
        check_val("rst_addr",     32'(addr_a),    0);
        check_val("rst_wr_en",    32'(wr_en_a),   0);
        check_val("rst_wr_data",  32'(wr_data_a), 0);
        check_val("rst_inbyte",   32'(inb_a),     0);
        check_val("rst_bytes",    32'(byt_a),     0);
        check_val("rst_string",   32'(str_a),     0);
        check_val("rst_b_string", 32'(str_b),     0);
        reset = 1'b0;

        // All zeros, pattern 00000: first byte only 4 string windows.
        fill_a(8'h00, 8'h00);
        run_a("zeros", 128, 32, 252, 0, 0);

        // Alternating bits, pattern 10101, started from DONE, with start
        // re-pulsed during SCAN (must be ignored).
        fill_a(8'h55, 8'hA8);
        run_a("alt55_pulse", 64, 32, 126, 5, 8);

        // Single match crossing the byte0/byte1 boundary, pattern 11111.
        fill_a(8'h00, 8'hF8);
        img_a[0] = 8'h03;
        img_a[1] = 8'hE0;
        run_a("crossing", 0, 0, 1, 0, 0);

        // Top window of the first byte and bottom window of the last byte.
        fill_a(8'h00, 8'hF8);
        img_a[0]  = 8'hF8;
        img_a[31] = 8'h1F;
        run_a("edges", 2, 2, 2, 0, 0);

        // Reset in SCAN with i=10 (cycle 12), then a clean rerun.
        fill_a(8'h55, 8'hA8);
        clear_res();
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        reset = 1'b1;
        #1;
        check_val("midrst_ack",     32'(ack_a),     0);
        check_val("midrst_addr",    32'(addr_a),    0);
        check_val("midrst_wr_en",   32'(wr_en_a),   0);
        check_val("midrst_wr_data", 32'(wr_data_a), 0);
        check_val("midrst_string",  32'(str_a),     0);
        check_val("midrst_inbyte",  32'(inb_a),     0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        check_val("midrst_no_writes", wr_hits_a, 0);
        check_val("midrst_mem33",     32'(res_a[0]), 32'h5A);
        check_val("midrst_idle_addr", 32'(addr_a), 0);
        check_val("midrst_idle_ack",  32'(ack_a), 0);
        run_a("rerun", 64, 32, 126, 0, 0);

        // Instance B: 2-bit pattern over 64 zero bytes; memory saturates.
        begin
            int ack_cyc = 0;
            for (int i = 0; i < 64; i++) img_b[i] = 8'h00;
            img_b[100] = 8'h00;
            clear_res();
            @(negedge clk);
            start_b = 1'b1;
            for (int c = 1; c <= 150; c++) begin
                @(negedge clk);
                start_b = 1'b0;
                if (ack_b) begin
                    ack_cyc = c;
                    break;
                end
            end
            check_val("b_ack_cycle",  ack_cyc, 70);
            check_val("b_cnt_inbyte", 32'(inb_b), 448);
            check_val("b_cnt_bytes",  32'(byt_b), 64);
            check_val("b_cnt_string", 32'(str_b), 511);
            check_val("b_mem101", 32'(res_b[0]), 32'hFF);
            check_val("b_mem102", 32'(res_b[1]), 32'h40);
            check_val("b_mem103", 32'(res_b[2]), 32'hFF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
